mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares one single-port `memory` instance (valid/ready, `wr_rd` handshake) between two requesters, e.g. a processor and a DMA/test master. It accepts one request at a time, forwards it unchanged to the memory, and returns `rdata` and `ready` to the winning requester. A per-transaction watchdog aborts accesses that the memory never acknowledges. The block sits directly between the requesters and the memory port.

## Interface
- `WIDTH`, 8: data width
- `DEPTH`, 32: memory depth in words
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width
- `TIMEOUT`, 16: BUSY cycles allowed before abort (≥2)

Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

Ports (k = 0, 1):
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `valid_k`  in  1  requester k request
- `wr_rd_k`  in  1  1 = write, 0 = read
- `addr_k`  in  ADDR_WIDTH  requester k address
- `wdata_k`  in  WIDTH  requester k write data
- `rdata_k`  out  WIDTH  read data; equals `mem_rdata` when granted, else 0
- `ready_k`  out  1  transaction k completes this cycle
- `err_k`  out  1  transaction k aborted by timeout (only with `ready_k`)
- `mem_valid`  out  1  to memory `valid`
- `mem_wr_rd`  out  1  to memory `wr_rd`
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`
- `mem_wdata`  out  WIDTH  to memory `wdata`
- `mem_rdata`  in  WIDTH  from memory `rdata`
- `mem_ready`  in  1  from memory `ready`
- `busy`  out  1  high in BUSY state
- `grant`  out  1  index of current/last granted requester

## Operation
- FSM has two states: IDLE and BUSY.
- IDLE: `mem_valid` = 0. At a posedge with any `valid_k` = 1, pick the winner, latch its `wr_rd`/`addr`/`wdata` into the `mem_*` registers, set `grant`, and go to BUSY.
- Arbitration: if only one requester is valid, it wins. If both are valid, the requester ≠ `grant` (last served) wins. Strict alternation under continuous contention.
- BUSY: `mem_valid` = 1 and the `mem_*` outputs stay constant. `ready_k` = (`grant`==k) & (`mem_ready` | timeout_hit), combinational. `rdata_k` is forwarded combinationally from `mem_rdata` when granted.
- Completion: at the posedge where `mem_ready` = 1 (or timeout_hit), go to IDLE. `mem_valid` is 0 for at least one cycle between transactions.
- Watchdog: a counter clears on entry to BUSY and increments each BUSY cycle. timeout_hit = (count == TIMEOUT−1) & ~`mem_ready`. On timeout, `err_k` = 1 together with `ready_k` for that cycle; the memory access is abandoned (possible write not guaranteed).
- Requester rule: hold inputs stable from `valid_k` until `ready_k`. A `valid_k` still high in the IDLE cycle after completion is a new request.
- A requester changing inputs while BUSY for the other requester has no effect until it is granted.

## Timing
- Reset values: state IDLE; `mem_valid`, `mem_wr_rd`, `ready_k`, `err_k`, `busy` = 0; `mem_addr`, `mem_wdata`, `rdata_k` = 0; `grant` = 1, so requester 0 wins the first tie; watchdog = 0.
- Latency: `valid_k` sampled at edge N gives `mem_valid` from cycle N+1. `ready_k` is in the same cycle as `mem_ready`.
- Minimum spacing is 2 cycles per transaction (1 IDLE + 1 BUSY with immediate `mem_ready`).
- `mem_ready` = 1 in IDLE is ignored, and `ready_k` stays 0.
- Simultaneous `mem_ready` and watchdog terminal count is a normal completion: `err_k` = 0.
- `rst` mid-BUSY: at that edge, go to IDLE, `mem_valid` → 0, `grant` → 1, no `ready_k` issued. The aborted requester must reissue.

## Test plan
- Single write then read: req0 writes 0xA5 to addr 15, then reads addr 15 → `mem_valid` one cycle after `valid0`; `ready0` with `rdata0` = 0xA5; `ready1` never asserts.
- Contention: `valid0`/`valid1` both held from reset, each with 4 writes (addr 0–3 and 16–19) → grant order 0,1,0,1,…; readback of all 8 addresses matches.
- Back-to-back: req1 issues 32 consecutive writes and reads over the full range (addr 0–31, wrapping at 31) → every transaction is separated by ≥1 cycle with `mem_valid` = 0; readback matches data.
- Timeout: memory model holds `mem_ready` = 0 → exactly 16 BUSY cycles, then `ready0` = `err0` = 1 for one cycle, FSM IDLE; a following normal access succeeds with `err0` = 0.
- Reset mid-transaction: assert `rst` in the 2nd BUSY cycle of req1's read → next cycle `mem_valid` = 0, `busy` = 0, `grant` = 1, no `ready1`; then with a tie, requester 0 wins.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the two requester ports and the memory port.
// master/slave carry the abort flag; mem_master/mem_slave are the memory-side view without it.
interface mem_arbiter_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH-1:0]      rdata;
   logic                  ready;
   logic                  err;

   modport master (
      output valid, wr_rd, addr, wdata,
      input  rdata, ready, err
   );

   modport slave (
      input  valid, wr_rd, addr, wdata,
      output rdata, ready, err
   );

   modport mem_master (
      output valid, wr_rd, addr, wdata,
      input  rdata, ready
   );

   modport mem_slave (
      input  valid, wr_rd, addr, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between two requesters,
// with a per-transaction watchdog that aborts accesses the memory never acknowledges.
module mem_arbiter #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_arbiter_if.slave       req0,
   mem_arbiter_if.slave       req1,
   mem_arbiter_if.mem_master  mem,
   output logic               busy,
   output logic               grant
);
   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_grant;
   logic                  r_wr_rd;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_wdata;
   logic [CW-1:0]         r_wdog;

   logic                  w_busy;
   logic                  w_any;
   logic                  w_win;
   logic                  w_timeout;
   logic                  w_done;
   logic                  w_sel_wr_rd;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [WIDTH-1:0]      w_sel_wdata;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_any       = req0.valid | req1.valid;
      w_win       = (req0.valid & req1.valid) ? ~r_grant : req1.valid;
      w_sel_wr_rd = w_win ? req1.wr_rd : req0.wr_rd;
      w_sel_addr  = w_win ? req1.addr  : req0.addr;
      w_sel_wdata = w_win ? req1.wdata : req0.wdata;
   end

   assign w_busy    = (r_state == S_BUSY);
   assign w_timeout = w_busy & (r_wdog == TERM) & ~mem.ready;
   assign w_done    = w_busy & (mem.ready | w_timeout);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_any)  w_next_state = S_BUSY;
         S_BUSY:  if (w_done) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant <= 1'b1;
         r_wr_rd <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wdog  <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_any) begin
            r_grant <= w_win;
            r_wr_rd <= w_sel_wr_rd;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wdog  <= '0;
         end
      end else begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign mem.valid = w_busy;
   assign mem.wr_rd = r_wr_rd;
   assign mem.addr  = r_addr;
   assign mem.wdata = r_wdata;

   // A memory acknowledge coinciding with the terminal count is a normal completion.
   assign req0.ready = w_done & ~r_grant;
   assign req1.ready = w_done &  r_grant;
   assign req0.err   = w_timeout & ~r_grant;
   assign req1.err   = w_timeout &  r_grant;
   assign req0.rdata = (w_busy & ~r_grant) ? mem.rdata : '0;
   assign req1.rdata = (w_busy &  r_grant) ? mem.rdata : '0;

   assign busy  = w_busy;
   assign grant = r_grant;
endmodule
